// File: rtl/matrix_capture_if.sv
// Pin-level bundle between an LED matrix driver and the capture block,
// plus the frame read port.
interface matrix_capture_if;
   logic        RCLK;
   logic        RSDI;
   logic        CCLK;
   logic        CSDI;
   logic        LE;
   logic        OEB;
   logic [3:0]  rd_row;
   logic [15:0] rd_data;
   logic        frame_tick;
   logic [15:0] latch_count;
   logic        multi_row_err;
   logic        blank;

   modport master (
      output RCLK, RSDI, CCLK, CSDI, LE, OEB, rd_row,
      input  rd_data, frame_tick, latch_count, multi_row_err, blank
   );

   modport slave (
      input  RCLK, RSDI, CCLK, CSDI, LE, OEB, rd_row,
      output rd_data, frame_tick, latch_count, multi_row_err, blank
   );
endinterface

// File: rtl/matrix_capture.sv
// Snoops the serial row/column streams of a 16x16 LED matrix driver and
// rebuilds the displayed frame in a readable 16-row buffer.
module matrix_capture #(
   parameter int SYNC_STAGES = 2
) (
   input logic             clk,
   input logic             reset,
   matrix_capture_if.slave bus
);
   localparam int TOP = SYNC_STAGES - 1;

   logic [SYNC_STAGES-1:0] rclk_s, cclk_s, le_s;
   logic [SYNC_STAGES-1:0] rsdi_s, csdi_s, oeb_s;
   logic                   rclk_prev, cclk_prev, le_prev;
   logic                   rclk_evt, cclk_evt, le_evt;
   logic                   multi_row;

   logic [15:0] row_sr;
   logic [15:0] col_sr;
   logic [15:0] frame [16];
   logic [15:0] rd_q;
   logic [15:0] latch_cnt;
   logic        err_q;
   logic        tick_q;

   // Strobe chains reset high so a pin already high at release is not an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         rclk_s    <= '1;
         cclk_s    <= '1;
         le_s      <= '1;
         rsdi_s    <= '0;
         csdi_s    <= '0;
         oeb_s     <= '0;
         rclk_prev <= 1'b1;
         cclk_prev <= 1'b1;
         le_prev   <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the old value, so the chain shifts one stage per clock.
         rclk_s    <= {rclk_s[SYNC_STAGES-2:0], bus.RCLK};
         cclk_s    <= {cclk_s[SYNC_STAGES-2:0], bus.CCLK};
         le_s      <= {le_s[SYNC_STAGES-2:0],   bus.LE};
         rsdi_s    <= {rsdi_s[SYNC_STAGES-2:0], bus.RSDI};
         csdi_s    <= {csdi_s[SYNC_STAGES-2:0], bus.CSDI};
         oeb_s     <= {oeb_s[SYNC_STAGES-2:0],  bus.OEB};
         rclk_prev <= rclk_s[TOP];
         cclk_prev <= cclk_s[TOP];
         le_prev   <= le_s[TOP];
      end
   end

   assign rclk_evt  = rclk_s[TOP] & ~rclk_prev;
   assign cclk_evt  = cclk_s[TOP] & ~cclk_prev;
   assign le_evt    = le_s[TOP]   & ~le_prev;
   assign multi_row = |(row_sr & (row_sr - 16'd1));

   // A commit reads row_sr/col_sr before any same-cycle shift lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         row_sr    <= '0;
         col_sr    <= '0;
         rd_q      <= '0;
         latch_cnt <= '0;
         err_q     <= 1'b0;
         tick_q    <= 1'b0;
         // NOTE: the frame buffer is cleared on reset because the reset frame is observable on rd_data; this keeps it in flops, not RAM.
         for (int i = 0; i < 16; i++) frame[i] <= '0;
      end else begin
         if (rclk_evt) row_sr <= {row_sr[14:0], rsdi_s[TOP]};
         if (cclk_evt) col_sr <= {col_sr[14:0], csdi_s[TOP]};
         tick_q <= le_evt & row_sr[15];
         if (le_evt) begin
            latch_cnt <= latch_cnt + 16'd1;
            if (multi_row) err_q <= 1'b1;
            for (int i = 0; i < 16; i++) begin
               if (row_sr[i]) frame[i] <= col_sr;
            end
         end
         rd_q <= frame[bus.rd_row];
      end
   end

   assign bus.rd_data       = rd_q;
   assign bus.frame_tick    = tick_q;
   assign bus.latch_count   = latch_cnt;
   assign bus.multi_row_err = err_q;
   assign bus.blank         = oeb_s[TOP];
endmodule

// File: tb/tb_matrix_capture.sv
// Self-checking bench for matrix_capture: pin-level shift/latch stimulus,
// a reference frame model and a queue of expected read results.
module tb_matrix_capture;
   logic clk = 1'b0;
   logic reset = 1'b1;

   matrix_capture_if mif ();

   matrix_capture #(.SYNC_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (mif)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          tick_cnt = 0;
   int          exp_ticks = 0;
   logic [15:0] model [16];
   logic [15:0] model_row, model_col;
   logic [15:0] exp_cnt;
   logic        exp_err;
   logic [15:0] exp_q [$];

   always @(negedge clk) if (mif.frame_tick === 1'b1) tick_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 16; i++) model[i] = '0;
      model_row = '0;
      model_col = '0;
      exp_cnt   = '0;
      exp_err   = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      clear_model();
   endtask

   task automatic commit_model();
      for (int i = 0; i < 16; i++) if (model_row[i]) model[i] = model_col;
      exp_cnt = exp_cnt + 16'd1;
      if ($countones(model_row) >= 2) exp_err = 1'b1;
      if (model_row[15]) exp_ticks++;
   endtask

   task automatic shift_words(input logic [15:0] row, input logic [15:0] col,
                              input int nbits, input bit do_row, input bit do_col);
      for (int b = nbits - 1; b >= 0; b--) begin
         mif.RSDI = row[b];
         mif.CSDI = col[b];
         repeat (2) @(negedge clk);
         if (do_row) begin
            mif.RCLK = 1'b1;
            model_row = {model_row[14:0], row[b]};
         end
         if (do_col) begin
            mif.CCLK = 1'b1;
            model_col = {model_col[14:0], col[b]};
         end
         repeat (2) @(negedge clk);
         if (do_row) mif.RCLK = 1'b0;
         if (do_col) mif.CCLK = 1'b0;
      end
      repeat (2) @(negedge clk);
   endtask

   // Returns at the fourth negedge after LE rises, i.e. at the read-latency bound.
   task automatic pulse_le();
      commit_model();
      mif.LE = 1'b1;
      repeat (2) @(negedge clk);
      mif.LE = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic read_check(input string tag, input int r);
      mif.rd_row = r[3:0];
      exp_q.push_back(model[r]);
      @(negedge clk);
      check($sformatf("%s row%0d", tag, r), {16'h0, mif.rd_data}, {16'h0, exp_q.pop_front()});
   endtask

   task automatic check_all_rows(input string tag);
      for (int r = 0; r < 16; r++) read_check(tag, r);
   endtask

   task automatic check_status(input string tag);
      check({tag, " latch_count"}, {16'h0, mif.latch_count}, {16'h0, exp_cnt});
      check({tag, " multi_row_err"}, {31'h0, mif.multi_row_err}, {31'h0, exp_err});
      check({tag, " frame_ticks"}, tick_cnt, exp_ticks);
   endtask

   initial begin
      mif.RCLK = 1'b0; mif.RSDI = 1'b0; mif.CCLK = 1'b0; mif.CSDI = 1'b0;
      mif.LE = 1'b0;   mif.OEB = 1'b1;  mif.rd_row = 4'd0;
      clear_model();

      // Reset state, sampled while reset is still asserted.
      repeat (3) @(negedge clk);
      check("reset rd_data", {16'h0, mif.rd_data}, 32'h0);
      check("reset latch_count", {16'h0, mif.latch_count}, 32'h0);
      check("reset multi_row_err", {31'h0, mif.multi_row_err}, 32'h0);
      check("reset frame_tick", {31'h0, mif.frame_tick}, 32'h0);
      check("reset blank", {31'h0, mif.blank}, 32'h0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("blank follows OEB high", {31'h0, mif.blank}, 32'h1);
      mif.OEB = 1'b0;
      repeat (3) @(negedge clk);
      check("blank follows OEB low", {31'h0, mif.blank}, 32'h0);

      // Basic single-row capture, checked at the latency bound.
      mif.rd_row = 4'd0;
      shift_words(16'h0001, 16'hA5C3, 16, 1'b1, 1'b1);
      exp_q.push_back(16'hA5C3);
      pulse_le();
      check("latency row0", {16'h0, mif.rd_data}, {16'h0, exp_q.pop_front()});
      check_status("basic");
      read_check("basic", 1);

      // Full 16-row scan.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         shift_words(16'h1 << i, 16'(16'h1111 * i), 16, 1'b1, 1'b1);
         pulse_le();
         repeat (2) @(negedge clk);
         check_status($sformatf("scan%0d", i));
      end
      check_all_rows("scan");

      // Multi-row commit sets the sticky error.
      shift_words(16'h0003, 16'hFFFF, 16, 1'b1, 1'b1);
      pulse_le();
      repeat (2) @(negedge clk);
      check_status("multi");
      shift_words(16'h0020, 16'h1234, 16, 1'b1, 1'b1);
      pulse_le();
      repeat (2) @(negedge clk);
      check_status("multi sticky");
      check_all_rows("multi");

      // Empty row word writes nothing; counter wraps.
      do_reset();
      shift_words(16'h0000, 16'hBEEF, 16, 1'b1, 1'b1);
      pulse_le();
      check_all_rows("norow");
      for (int k = 0; k < 3; k++) pulse_le();
      check_status("count");
      force dut.latch_cnt = 16'hFFFE;
      @(negedge clk);
      release dut.latch_cnt;
      exp_cnt = 16'hFFFE;
      pulse_le();
      pulse_le();
      check_status("wrap");
      pulse_le();
      check_status("after wrap");
      check_all_rows("wrap");

      // LE and RCLK rising together: commit sees the pre-shift row word.
      do_reset();
      shift_words(16'h0002, 16'h5A5A, 16, 1'b1, 1'b1);
      mif.RSDI = 1'b1;
      repeat (2) @(negedge clk);
      commit_model();
      model_row = {model_row[14:0], 1'b1};
      mif.LE = 1'b1; mif.RCLK = 1'b1;
      repeat (2) @(negedge clk);
      mif.LE = 1'b0; mif.RCLK = 1'b0;
      repeat (2) @(negedge clk);
      check_all_rows("same-cycle");
      pulse_le();
      check_all_rows("post-shift");
      check_status("same-cycle");

      // RCLK held high through reset release must not shift.
      mif.RCLK = 1'b1; mif.RSDI = 1'b1;
      do_reset();
      shift_words(16'h0000, 16'hCAFE, 16, 1'b0, 1'b1);
      mif.RCLK = 1'b0;
      repeat (4) @(negedge clk);
      mif.RSDI = 1'b0;
      pulse_le();
      read_check("rclk-hold", 0);
      check_status("rclk-hold");

      // Reset mid-shift discards the partial words.
      do_reset();
      shift_words(16'hFFFF, 16'hFFFF, 8, 1'b1, 1'b1);
      do_reset();
      shift_words(16'h0008, 16'h3C96, 16, 1'b1, 1'b1);
      pulse_le();
      check_all_rows("midreset");
      check_status("midreset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/matrix_capture.md
MATRIX_CAPTURE -- requirements
Module: matrix_capture

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of input synchronizer flops per serial input (minimum 2).
REQ-002 clk  input  1  system clock; the single clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 RCLK  input  1  row shift clock from the matrix driver; data shifts on its rising edge.
REQ-005 RSDI  input  1  row serial data; 1 = row selected.
REQ-006 CCLK  input  1  column shift clock; data shifts on its rising edge.
REQ-007 CSDI  input  1  column serial data; 1 = pixel lit.
REQ-008 LE  input  1  latch enable; rising edge commits the shifted row/column words.
REQ-009 OEB  input  1  output-enable-bar; low = display enabled.
REQ-010 rd_row  input  4  frame read address (row index).
REQ-011 rd_data  output  16  registered column word of frame[rd_row].
REQ-012 frame_tick  output  1  one-cycle pulse when row 15 is written.
REQ-013 latch_count  output  16  number of LE rising edges seen, wraps at 65535 -> 0.
REQ-014 multi_row_err  output  1  sticky flag: an LE commit with more than one row bit set.
REQ-015 blank  output  1  synchronized OEB (1 = display blanked).

Function
REQ-016 Each of RCLK, RSDI, CCLK, CSDI, LE and OEB SHALL pass through SYNC_STAGES flops on clk before use; data inputs SHALL use the same stage count as their clocks, keeping them aligned.
REQ-017 The design SHALL detect a rising edge as: synchronized value = 1 and the previous synchronized value = 0; an edge SHALL produce exactly one single-cycle event.
REQ-018 On an RCLK event: row_sr <= {row_sr[14:0], RSDI_sync}. On a CCLK event: col_sr <= {col_sr[14:0], CSDI_sync}. After 16 shifts, the first bit shifted in SHALL be at bit 15.
REQ-019 Shifting SHALL be unlimited; more than 16 shifts discard the oldest bits, and no error is raised.
REQ-020 On an LE event, for every i with row_sr[i]=1, the design SHALL write frame[i] <= col_sr; if row_sr = 0, no row SHALL be written.
REQ-021 If an LE event occurs in the same cycle as an RCLK or CCLK event, the commit SHALL use the shift-register values from before that cycle's shift; the shift SHALL still take effect.
REQ-022 On an LE event, latch_count SHALL increment by 1, modulo 2^16.
REQ-023 On an LE event with popcount(row_sr) >= 2, multi_row_err SHALL set to 1 and hold until reset; the write of REQ-020 still occurs.
REQ-024 frame_tick SHALL be 1 in the cycle after an LE commit where row_sr[15]=1, and 0 otherwise.
REQ-025 The frame write SHALL be visible on rd_data no later than SYNC_STAGES+2 cycles after LE rises at the pin.
REQ-026 rd_data SHALL equal frame[rd_row] as sampled on the previous clk edge (1-cycle read latency); a same-cycle write and read of one row SHALL return the old value.
REQ-027 blank SHALL equal the final OEB sync stage; OEB SHALL NOT gate capture.
REQ-028 Input protocol requirement: each RCLK, CCLK and LE high and low phase SHALL last at least 2 clk cycles, and data SHALL be stable for 1 cycle around the shift-clock rising edge; shorter pulses are outside the specified behaviour.

Reset
REQ-029 While reset=1 at a clk edge, the design SHALL clear to 0: row_sr, col_sr, all 16 frame rows, rd_data, latch_count, multi_row_err, frame_tick, blank and all data sync flops.
REQ-030 During reset, the clock/LE sync and previous-value flops SHALL load 1; an input held high through reset release SHALL NOT produce an event.
REQ-031 A reset asserted mid-shift or mid-frame SHALL discard the partial words; no commit SHALL occur in the reset cycle.

Verification
REQ-032 Shift RSDI bits 0x0001 (MSB first) on RCLK and CSDI bits 0xA5C3 on CCLK, then pulse LE; set rd_row=0 -> rd_data=0xA5C3, latch_count=1, frame_tick=0, multi_row_err=0.
REQ-033 Scan 16 rows (row_sr=1<<i, col=0x1111*i mod 0x10000) -> rd_data per row matches; frame_tick pulses once, after the row-15 LE; latch_count=16.
REQ-034 Commit with row_sr=0x0003 and col=0xFFFF -> rows 0 and 1 = 0xFFFF, multi_row_err=1 and stays 1 after further single-row commits.
REQ-035 Commit with row_sr=0, then 65536 LE pulses from reset -> no frame change, latch_count wraps to 0.
REQ-036 Raise LE in the same cycle as an RCLK edge -> commit uses the pre-shift row_sr. Hold RCLK high across reset release -> row_sr stays 0.
REQ-037 Assert reset after 8 column shifts, then do a full 16-bit shift and LE -> captured row equals the new 16 bits only, and all other rows are 0.
